// File: rtl/uart_tx_fifo_if.sv
// Host-side port bundle for the buffered UART transmitter.
// The host drives din/wr; the transmitter returns FIFO status and the serial line.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 2
);
  logic [7:0]       din;
  logic             wr;
  logic             full;
  logic [FIFO_AW:0] count;
  logic             busy;
  logic             tx;

  modport master (output din, wr, input full, count, busy, tx);
  modport slave  (input din, wr, output full, count, busy, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a frame serialiser
// that sends queued bytes back-to-back with no idle gap between frames.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (tx=0) for BCLK+1 clocks
// DATA  | eight data bits, LSB first, BCLK+1 clocks each
// STOP  | stop bit (tx=1); pops the next byte at its end if one is queued
module uart_tx_fifo #(
  parameter logic [9:0] BCLK    = 10'd433,
  parameter int         FIFO_AW = 2
) (
  input logic          clk,
  input logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               full, push, pop;
  logic [9:0]         cyc_q, cyc_nxt;
  logic [2:0]         bi_q, bi_nxt;
  logic [7:0]         sr_q, sr_nxt;
  logic               tx_q, tx_nxt;
  logic               tc, have_data;

  assign full      = (count_q == (FIFO_AW+1)'(DEPTH));
  assign push      = bus.wr && !full;
  assign have_data = (count_q != '0);
  // Bit timer counts down from BCLK; terminal count marks the last clock of a bit.
  assign tc        = (cyc_q == '0);

  assign bus.full  = full;
  assign bus.count = count_q;
  assign bus.tx    = tx_q;
  assign bus.busy  = (state != IDLE) || have_data;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = tx_q;
    cyc_nxt   = tc ? '0 : cyc_q - 10'd1;
    bi_nxt    = bi_q;
    sr_nxt    = sr_q;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (have_data) begin
          pop       = 1'b1;
          sr_nxt    = mem[rd_ptr];
          tx_nxt    = 1'b0;
          cyc_nxt   = BCLK;
          state_nxt = START;
        end
      end
      START: begin
        if (tc) begin
          tx_nxt    = sr_q[0];
          cyc_nxt   = BCLK;
          bi_nxt    = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tc) begin
          cyc_nxt = BCLK;
          if (bi_q == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            sr_nxt = {1'b0, sr_q[7:1]};
            tx_nxt = sr_q[1];
            bi_nxt = bi_q + 3'd1;
          end
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (tc) begin
          if (have_data) begin
            pop       = 1'b1;
            sr_nxt    = mem[rd_ptr];
            tx_nxt    = 1'b0;
            cyc_nxt   = BCLK;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      cyc_q   <= '0;
      bi_q    <= '0;
      sr_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state <= state_nxt;
      tx_q  <= tx_nxt;
      cyc_q <= cyc_nxt;
      bi_q  <= bi_nxt;
      sr_q  <= sr_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BCLK=3 (4 clk/bit); a line monitor decodes
// frames from tx so byte order, stop bits and frame spacing can be compared.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  logic [7:0] byte_q[$];
  int         t_q[$];
  logic       stop_q[$];

  uart_tx_fifo_if #(.FIFO_AW(2)) bus ();

  uart_tx_fifo #(.BCLK(10'd3), .FIFO_AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.din = d;
    bus.wr  = 1'b1;
    @(negedge clk);
    bus.wr  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1'b1);
  endtask

  task automatic clear_mon();
    byte_q.delete();
    t_q.delete();
    stop_q.delete();
  endtask

  task automatic check_frames(input string tag, input logic [7:0] exp[], input int gapless);
    check({tag, "_n"}, byte_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < byte_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), byte_q[i], exp[i]);
      check($sformatf("%s_stop%0d", tag, i), stop_q[i], 1'b1);
      if (gapless != 0 && i > 0)
        check($sformatf("%s_gap%0d", tag, i), t_q[i] - t_q[i-1], 40);
    end
  endtask

  // Line monitor: frame start seen at negedge s, bit k centre at s+4k+2.
  initial begin
    logic [7:0] b;
    int         t0;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        t0 = cyc_cnt;
        repeat (6) @(negedge clk);
        b[0] = bus.tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (4) @(negedge clk);
        stop_q.push_back(bus.tx);
        repeat (1) @(negedge clk);
        byte_q.push_back(b);
        t_q.push_back(t0);
      end
    end
  end

  initial begin
    logic [39:0] got, exp;
    logic [9:0]  fr;
    logic        busy_all;
    int          lows;

    reset   = 1'b1;
    bus.wr  = 1'b0;
    bus.din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_count", bus.count, 3'd0);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: timing of every tx clock
    write_byte(8'h55);
    check("t1_count_after_wr", bus.count, 3'd1);
    check("t1_tx_still_high", bus.tx, 1'b1);
    check("t1_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_popped", bus.count, 3'd0);
    fr = {1'b1, 8'h55, 1'b0};
    busy_all = 1'b1;
    for (int k = 0; k < 40; k++) begin
      exp[k] = fr[k/4];
      got[k] = bus.tx;
      busy_all &= bus.busy;
      @(negedge clk);
    end
    check("t1_waveform", got, exp);
    check("t1_busy_all", busy_all, 1'b1);
    check("t1_tx_end", bus.tx, 1'b1);
    check("t1_busy_end", bus.busy, 1'b0);

    // Burst of five on consecutive edges
    clear_mon();
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'hA5);
    write_byte(8'h3C);
    write_byte(8'h81);
    check("t2_count", bus.count, 3'd4);
    check("t2_full", bus.full, 1'b1);
    wait_idle("t2_idle", 400);
    check_frames("t2", '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81}, 1);

    // Overflow: hold wr for 10 clk during a frame
    clear_mon();
    write_byte(8'h10);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.din = 8'h20 + 8'(i);
      bus.wr  = 1'b1;
      @(negedge clk);
    end
    bus.wr = 1'b0;
    check("t3_count_sat", bus.count, 3'd4);
    check("t3_full", bus.full, 1'b1);
    wait_idle("t3_idle", 400);
    check_frames("t3", '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23}, 1);

    // Push and pop on the same edge (in IDLE, then at end of STOP)
    clear_mon();
    write_byte(8'h5A);
    write_byte(8'hC6);
    check("t6_idle_pushpop", bus.count, 3'd1);
    repeat (39) @(negedge clk);
    write_byte(8'h37);
    check("t6_stop_pushpop", bus.count, 3'd1);
    check("t6_next_start", bus.tx, 1'b0);
    wait_idle("t6_idle", 300);
    check_frames("t6", '{8'h5A, 8'hC6, 8'h37}, 1);

    // Reset during data bit 3 of 0xC3 with two bytes queued
    write_byte(8'hC3);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (15) @(negedge clk);
    check("t4_pre_count", bus.count, 3'd2);
    check("t4_pre_bit3", bus.tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_tx", bus.tx, 1'b1);
    check("t4_count", bus.count, 3'd0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_full", bus.full, 1'b0);
    repeat (60) @(negedge clk);
    clear_mon();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.tx !== 1'b1) lows++;
      @(negedge clk);
    end
    check("t4_quiet", lows, 0);
    check("t4_no_frames", byte_q.size(), 0);
    check("t4_still_idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
